operate_uart_sender: RTL

//  Receiving end of the traveler operate-code bus: samples the 8-bit op_data bus every clk.

---
 rtl/operate_uart_sender_pkg.sv | 31 +++
 rtl/operate_uart_sender_op_fifo.sv | 69 ++++++
 rtl/operate_uart_sender.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/operate_uart_sender_pkg.sv
// Shared definitions for the operate-code UART sender.
// Holds the operate code values shared with the button operate machine,
// the UART sender state encodings and the baud divisor helper.
package operate_uart_sender_pkg;

    localparam int unsigned BYTE_W = 8;

    // Operate codes on the op_data bus; IGNORE marks an idle cycle
    typedef enum logic [BYTE_W-1:0] {
        OPERATE_IGNORE   = 8'h00,
        OPERATE_GET      = 8'h01,
        OPERATE_PUT      = 8'h02,
        OPERATE_INTERACT = 8'h03,
        OPERATE_THROW    = 8'h04
    } operate_code_e;

    // UART sender states; PARITY is only reachable in the 8E1 build
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Bit period in clock cycles (integer divide)
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/operate_uart_sender_op_fifo.sv
// Synchronous FIFO queueing operate bytes for the UART sender.
// Pointers carry one extra wrap bit; full/empty are registered flags
// computed from the next pointer values.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   push, din    write request and data (ignored when full unless popping)
//   pop, dout    read request and head-of-queue data (dout valid when !empty)
//   full, empty  registered occupancy flags
//   empty_nxt_c  combinational empty flag after the current edge
module operate_uart_sender_op_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             empty_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;
    logic             full_nxt;

    // A push into a full FIFO succeeds only when the head is freed this cycle
    assign do_pop      = pop & ~empty;
    assign do_push     = push & (~full | do_pop);
    assign wr_ptr_nxt  = wr_ptr + PW'(do_push);
    assign rd_ptr_nxt  = rd_ptr + PW'(do_pop);
    assign empty_nxt_c = (wr_ptr_nxt == rd_ptr_nxt);
    assign full_nxt    = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                         (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    assign dout        = mem[rd_ptr[AW-1:0]];

    // Pointers and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= full_nxt;
            empty  <= empty_nxt_c;
        end
    end

    // Storage; reads are combinational so a full push+pop reads the old head
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/operate_uart_sender.sv
// Operate-code UART sender: queues every non-IGNORE op_data byte and sends
// it LSB-first on tx (8N1, or 8E1 when OPERATE_TX_PARITY_EN is defined).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   op_data     operate code sampled every cycle; 8'h00 = no operation
//   tx          UART line, idle high
//   busy        frame in progress or bytes queued
//   fifo_full   FIFO holds FIFO_DEPTH bytes
//   drop_cnt    saturating count of bytes lost to a full FIFO
// Configuration macro: OPERATE_TX_PARITY_EN (even parity bit after data).
module operate_uart_sender
    import operate_uart_sender_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] op_data,
    output logic              tx,
    output logic              busy,
    output logic              fifo_full,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    uart_state_e       state;
    uart_state_e       state_nxt;
    logic [CNT_W-1:0]  baud_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_nxt;
    logic [BYTE_W-1:0] shift;
    logic [BYTE_W-1:0] shift_nxt;
    logic              tx_nxt;
    logic              busy_nxt;
    logic              bit_done_c;
    logic              op_push_c;
    logic              pop_c;
    logic              drop_c;
    logic [BYTE_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_empty_nxt_c;
`ifdef OPERATE_TX_PARITY_EN
    logic              par_bit;
`endif

    assign op_push_c  = (op_data != OPERATE_IGNORE);
    assign bit_done_c = (baud_cnt == CNT_LAST);
    assign drop_c     = op_push_c & fifo_full & ~pop_c;

    operate_uart_sender_op_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_op_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (op_push_c),
        .din         (op_data),
        .pop         (pop_c),
        .dout        (fifo_dout),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .empty_nxt_c (fifo_empty_nxt_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, baud/bit counters, shifter and line value
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_done_c ? '0 : baud_cnt + CNT_W'(1);
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        pop_c     = 1'b0;
        tx_nxt    = 1'b1;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    shift_nxt = fifo_dout;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (bit_done_c) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done_c) begin
                    shift_nxt = {1'b0, shift[BYTE_W-1:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef OPERATE_TX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef OPERATE_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done_c) begin
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_c) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Line is registered from the next state so it changes with the state
        case (state_nxt)
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = shift_nxt[0];
`ifdef OPERATE_TX_PARITY_EN
            ST_PARITY: tx_nxt = par_bit;
`endif
            default:  tx_nxt = 1'b1;
        endcase

        busy_nxt = (state_nxt != ST_IDLE) | ~fifo_empty_nxt_c;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            baud_cnt <= cnt_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
            if (drop_c && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

`ifdef OPERATE_TX_PARITY_EN
    // Even parity of the byte, captured when it leaves the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit <= 1'b0;
        end else if (pop_c) begin
            par_bit <= ^fifo_dout;
        end
    end
`endif

endmodule
